// File: rtl/fetch_stage_if.sv
// ----------------------------------------------------------------------------
// fetch_stage_if
//   Instruction-memory request/acknowledge bus between the fetch stage and
//   instruction memory.
//
//   Handshake: the fetch stage raises imem_req with a byte address on
//   imem_addr. It keeps both stable until the memory returns imem_ack=1 for
//   one cycle with the word on imem_rdata. That cycle completes the request.
//   Latency from req to ack is unbounded and variable. A new request, if any,
//   is presented from the following cycle.
//
//   Signals
//     imem_req    fetch stage -> memory   request pending
//     imem_addr   fetch stage -> memory   byte address of the request
//     imem_ack    memory -> fetch stage   imem_rdata valid, request done
//     imem_rdata  memory -> fetch stage   fetched instruction word
//
//   Modports: master = fetch stage, slave = memory.
// ----------------------------------------------------------------------------
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage plus the IF/ID pipeline register. It holds the PC
//   and fetches words over a variable-latency req/ack memory bus. It presents
//   {pc+PC_STEP, inst, inst_valid} to decode, honours the hazard freeze and
//   redirects on taken branches from EXE. Bubbles carry NOP_INST with
//   inst_valid=0.
//
//   Ports
//     clk           clock, all state updates on posedge
//     rst           synchronous, active-high reset
//     freeze        hazard stall: hold PC and IF/ID register
//     branch_taken  EXE branch resolved taken (one-cycle pulse)
//     branch_addr   branch target byte address (no alignment check)
//     bus           instruction-memory interface (master side)
//     pc_out        IF/ID: PC+PC_STEP of the held instruction
//     inst          IF/ID: instruction word
//     inst_valid    IF/ID: 1 = real instruction, 0 = bubble
//     fsm_state     current fetch FSM state, for observation
//
//   FSM states
//     IDLE     after reset; no request
//     REQ      request at pc outstanding
//     DISCARD  wrong-path request still in flight; its data is dropped
//     HOLD     word received during freeze, parked in the hold buffer
// ----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freeze,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_addr,
    fetch_stage_if.master        bus,
    output logic [31:0]          pc_out,
    output logic [31:0]          inst,
    output logic                 inst_valid,
    output logic [1:0]           fsm_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] redirect_pc, redirect_next;
    logic [31:0] hold_buf, hold_next;
    logic [31:0] pc_out_next;
    logic [31:0] inst_next;
    logic        valid_next;
    logic [31:0] pc_inc;

    // Modulo-2^32 increment: 32'hFFFF_FFFC wraps to 0.
    assign pc_inc = pc + PC_STEP;

    // pc is not advanced until a request completes on the right path, so in
    // both REQ and DISCARD it is the address of the outstanding request.
    // The address therefore stays stable for as long as req is high.
    assign bus.imem_req  = (state == REQ) || (state == DISCARD);
    assign bus.imem_addr = pc;
    assign fsm_state     = state;

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        redirect_next = redirect_pc;
        hold_next     = hold_buf;
        pc_out_next   = pc_out;
        inst_next     = inst;
        valid_next    = inst_valid;

        case (state)
            IDLE: begin
                state_next = REQ;
                if (branch_taken) begin
                    pc_next    = branch_addr;
                    inst_next  = NOP_INST;
                    valid_next = 1'b0;
                end
            end

            REQ: begin
                if (bus.imem_ack) begin
                    if (branch_taken) begin
                        // The word just returned is on the wrong path.
                        pc_next    = branch_addr;
                        inst_next  = NOP_INST;
                        valid_next = 1'b0;
                    end else if (freeze) begin
                        // Decode cannot take the word yet; park it so it is
                        // neither lost nor fetched twice.
                        hold_next  = bus.imem_rdata;
                        state_next = HOLD;
                    end else begin
                        pc_out_next = pc_inc;
                        inst_next   = bus.imem_rdata;
                        valid_next  = 1'b1;
                        pc_next     = pc_inc;
                    end
                end else begin
                    if (branch_taken) begin
                        // Request cannot be withdrawn; finish it in DISCARD.
                        redirect_next = branch_addr;
                        inst_next     = NOP_INST;
                        valid_next    = 1'b0;
                        state_next    = DISCARD;
                    end else if (!freeze) begin
                        inst_next  = NOP_INST;
                        valid_next = 1'b0;
                    end
                end
            end

            DISCARD: begin
                if (branch_taken) begin
                    redirect_next = branch_addr;
                end
                if (bus.imem_ack) begin
                    pc_next    = branch_taken ? branch_addr : redirect_pc;
                    state_next = REQ;
                end
                if (branch_taken || !freeze) begin
                    inst_next  = NOP_INST;
                    valid_next = 1'b0;
                end
            end

            HOLD: begin
                if (branch_taken) begin
                    pc_next    = branch_addr;
                    inst_next  = NOP_INST;
                    valid_next = 1'b0;
                    state_next = REQ;
                end else if (!freeze) begin
                    pc_out_next = pc_inc;
                    inst_next   = hold_buf;
                    valid_next  = 1'b1;
                    pc_next     = pc_inc;
                    state_next  = REQ;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            redirect_pc <= RESET_PC;
            hold_buf    <= 32'h0;
            pc_out      <= 32'h0;
            inst        <= NOP_INST;
            inst_valid  <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            redirect_pc <= redirect_next;
            hold_buf    <= hold_next;
            pc_out      <= pc_out_next;
            inst        <= inst_next;
            inst_valid  <= valid_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//   Cycle-by-cycle directed bench for fetch_stage. Each step drives
//   rst/freeze/branch/ack for one cycle. It checks imem_req/imem_addr before
//   the edge and the IF/ID outputs after it. The memory word for address a
//   is a ^ 32'hA5A5_0000.
//   Check modes: 0 = no IF/ID check, 1 = inst/valid only, 2 = pc_out too.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] K = 32'hA5A5_0000;

    typedef struct {
        logic        rst;
        logic        freeze;
        logic        br;
        logic [31:0] baddr;
        logic        ack;
        logic        chk_req;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [1:0]  mode;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = 32'h0;
    logic [31:0] pc_out;
    logic [31:0] inst;
    logic        inst_valid;
    logic [1:0]  fsm_state;

    int total = 0;
    int bad = 0;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .bus          (bus),
        .pc_out       (pc_out),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .fsm_state    (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [31:0] w(input logic [31:0] a);
        return a ^ K;
    endfunction

    function automatic vec_t mk(input int r, input int f, input int b,
                                input logic [31:0] ba, input int a,
                                input int cr, input int er, input logic [31:0] ea,
                                input int m, input int ev,
                                input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.rst       = (r != 0);
        v.freeze    = (f != 0);
        v.br        = (b != 0);
        v.baddr     = ba;
        v.ack       = (a != 0);
        v.chk_req   = (cr != 0);
        v.exp_req   = (er != 0);
        v.exp_addr  = ea;
        v.mode      = 2'(m);
        v.exp_valid = (ev != 0);
        v.exp_pc    = ep;
        v.exp_inst  = ei;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- driver: one cycle ----------------
    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        rst              = v.rst;
        freeze           = v.freeze;
        branch_taken     = v.br;
        branch_addr      = v.baddr;
        bus.imem_ack     = v.ack;
        bus.imem_rdata   = v.ack ? w(v.exp_addr) : 32'hDEAD_BEEF;
        #1;
        if (v.chk_req) begin
            chk({tag, " req"}, {31'h0, bus.imem_req}, {31'h0, v.exp_req});
            if (v.exp_req)
                chk({tag, " addr"}, bus.imem_addr, v.exp_addr);
        end
        @(posedge clk);
        #1;
        if (v.mode != 2'd0) begin
            chk({tag, " valid"}, {31'h0, inst_valid}, {31'h0, v.exp_valid});
            chk({tag, " inst"}, inst, v.exp_inst);
        end
        if (v.mode == 2'd2)
            chk({tag, " pc_out"}, pc_out, v.exp_pc);
    endtask

    task automatic do_reset(input string tag);
        step(mk(1,0,0,32'h0,0, 0,0,32'h0, 2,0,32'h0,32'h0), {tag, " rst"});
        step(mk(0,0,0,32'h0,0, 1,0,32'h0, 2,0,32'h0,32'h0), {tag, " idle"});
    endtask

    // ---------------- stimulus ----------------
    vec_t tbl [11];

    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;

        // Zero-wait fetches, then 3-cycle-latency fetches.
        tbl[0]  = mk(1,0,0,32'h0,0, 0,0,32'h0,  2,0,32'h0,  32'h0);
        tbl[1]  = mk(0,0,0,32'h0,0, 1,0,32'h0,  2,0,32'h0,  32'h0);
        tbl[2]  = mk(0,0,0,32'h0,1, 1,1,32'h0,  2,1,32'h4,  w(32'h0));
        tbl[3]  = mk(0,0,0,32'h0,1, 1,1,32'h4,  2,1,32'h8,  w(32'h4));
        tbl[4]  = mk(0,0,0,32'h0,1, 1,1,32'h8,  2,1,32'hC,  w(32'h8));
        tbl[5]  = mk(0,0,0,32'h0,0, 1,1,32'hC,  1,0,32'h0,  32'h0);
        tbl[6]  = mk(0,0,0,32'h0,0, 1,1,32'hC,  1,0,32'h0,  32'h0);
        tbl[7]  = mk(0,0,0,32'h0,1, 1,1,32'hC,  2,1,32'h10, w(32'hC));
        tbl[8]  = mk(0,0,0,32'h0,0, 1,1,32'h10, 1,0,32'h0,  32'h0);
        tbl[9]  = mk(0,0,0,32'h0,0, 1,1,32'h10, 1,0,32'h0,  32'h0);
        tbl[10] = mk(0,0,0,32'h0,1, 1,1,32'h10, 2,1,32'h14, w(32'h10));

        for (int i = 0; i < 11; i++)
            step(tbl[i], $sformatf("vec%0d", i));

        // Freeze for 4 cycles starting on the ack of addr 8.
        do_reset("frz");
        step(mk(0,0,0,32'h0,1, 1,1,32'h0, 2,1,32'h4, w(32'h0)), "frz a0");
        step(mk(0,0,0,32'h0,1, 1,1,32'h4, 2,1,32'h8, w(32'h4)), "frz a4");
        step(mk(0,1,0,32'h0,1, 1,1,32'h8, 2,1,32'h8, w(32'h4)), "frz ack8");
        for (int i = 0; i < 3; i++)
            step(mk(0,1,0,32'h0,0, 1,0,32'h0, 2,1,32'h8, w(32'h4)), $sformatf("frz hold%0d", i));
        step(mk(0,0,0,32'h0,0, 1,0,32'h0, 2,1,32'hC,  w(32'h8)), "frz release");
        step(mk(0,0,0,32'h0,1, 1,1,32'hC, 2,1,32'h10, w(32'hC)), "frz a12");

        // Branch while addr 12 is outstanding; ack two cycles later.
        do_reset("br");
        step(mk(0,0,0,32'h0,1, 1,1,32'h0, 2,1,32'h4, w(32'h0)), "br a0");
        step(mk(0,0,0,32'h0,1, 1,1,32'h4, 2,1,32'h8, w(32'h4)), "br a4");
        step(mk(0,0,0,32'h0,1, 1,1,32'h8, 2,1,32'hC, w(32'h8)), "br a8");
        step(mk(0,0,1,32'h40,0, 1,1,32'hC, 1,0,32'h0, 32'h0), "br take");
        step(mk(0,0,0,32'h0,0,  1,1,32'hC, 1,0,32'h0, 32'h0), "br disc wait");
        step(mk(0,0,0,32'h0,1,  1,1,32'hC, 1,0,32'h0, 32'h0), "br disc ack");
        step(mk(0,0,0,32'h0,1,  1,1,32'h40, 2,1,32'h44, w(32'h40)), "br target");
        // A second branch during DISCARD replaces the redirect target.
        step(mk(0,0,1,32'h100,0, 1,1,32'h44, 1,0,32'h0, 32'h0), "br2 take");
        step(mk(0,0,1,32'h200,0, 1,1,32'h44, 1,0,32'h0, 32'h0), "br2 retake");
        step(mk(0,0,0,32'h0,1,   1,1,32'h44, 1,0,32'h0, 32'h0), "br2 disc ack");
        step(mk(0,0,0,32'h0,1,   1,1,32'h200, 2,1,32'h204, w(32'h200)), "br2 target");

        // Branch and freeze together: REQ with ack, HOLD, REQ without ack.
        do_reset("bf");
        step(mk(0,0,0,32'h0,1,  1,1,32'h0, 2,1,32'h4, w(32'h0)), "bf a0");
        step(mk(0,1,1,32'h80,1, 1,1,32'h4, 1,0,32'h0, 32'h0), "bf req ack");
        step(mk(0,0,0,32'h0,1,  1,1,32'h80, 2,1,32'h84, w(32'h80)), "bf target");
        step(mk(0,1,0,32'h0,1,  1,1,32'h84, 2,1,32'h84, w(32'h80)), "bf to hold");
        step(mk(0,1,1,32'hFFFF_FFFC,0, 1,0,32'h0, 1,0,32'h0, 32'h0), "bf hold");
        step(mk(0,0,0,32'h0,1,  1,1,32'hFFFF_FFFC, 2,1,32'h0, w(32'hFFFF_FFFC)), "bf wrap");
        step(mk(0,0,0,32'h0,1,  1,1,32'h0, 2,1,32'h4, w(32'h0)), "bf after wrap");
        step(mk(0,1,1,32'h300,0, 1,1,32'h4, 1,0,32'h0, 32'h0), "bf req noack");
        step(mk(0,0,0,32'h0,1,  1,1,32'h4, 1,0,32'h0, 32'h0), "bf disc ack");
        step(mk(0,0,0,32'h0,1,  1,1,32'h300, 2,1,32'h304, w(32'h300)), "bf target2");

        // Reset while a request is waiting.
        do_reset("rw");
        step(mk(0,0,0,32'h0,1, 1,1,32'h0, 2,1,32'h4, w(32'h0)), "rw a0");
        step(mk(0,1,0,32'h0,0, 1,1,32'h4, 2,1,32'h4, w(32'h0)), "rw wait");
        step(mk(1,1,0,32'h0,0, 1,1,32'h4, 2,0,32'h0, 32'h0), "rw rst");
        chk("rw state", {30'h0, fsm_state}, 32'h0);
        step(mk(0,0,0,32'h0,0, 1,0,32'h0, 2,0,32'h0, 32'h0), "rw idle");
        step(mk(0,0,0,32'h0,1, 1,1,32'h0, 2,1,32'h4, w(32'h0)), "rw restart");

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
